reorder_buffer: RTL and testbench

- Circular in-order reorder buffer for the Tomasulo core; the producer side of the commit/mispredict interface that the register file consumes.
- Allocates one entry per dispatched instruction and returns its ROB id as the rename tag.
- Captures results from the CDB, answers dispatcher operand lookups by ROB id, and retires one instruction per cycle in order.
- Raises a one-cycle mispredict with the redirect PC when a committing branch's prediction was wrong.

---
 rtl/reorder_buffer_pkg.sv | 33 +++
 rtl/rob_entry_array.sv | 87 ++++++++
 rtl/reorder_buffer.sv | 121 ++++++++++++
 tb/tb_reorder_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants, tag types and the per-entry record.
// Imported by the entry array and the reorder buffer top.
package reorder_buffer_pkg;

  localparam int ROB_SIZE            = 16;
  localparam int ROB_ID_W            = 5;
  localparam int ROB_IDX_W           = 4;
  localparam int EX_REG_NUMBER_WIDTH = 6;
  localparam int DATA_WIDTH          = 32;

  typedef logic [ROB_ID_W-1:0]            rob_id_t;
  typedef logic [ROB_IDX_W-1:0]           rob_idx_t;
  typedef logic [EX_REG_NUMBER_WIDTH-1:0] ex_reg_t;

  localparam rob_id_t NON_DEPENDENT = rob_id_t'(ROB_SIZE);
  localparam ex_reg_t REG_NUMBER    = ex_reg_t'(32);

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    ex_reg_t               rd;
    logic                  is_br;
    logic                  pred;
    logic                  taken;
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] target;
  } rob_entry_t;

  function automatic logic writes_rd(ex_reg_t rd);
    return (rd != '0) && (rd != REG_NUMBER);
  endfunction

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage with two CDB-bypassed operand lookup ports.
// Write enables arrive already qualified by the pointer control.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_en,
  input  logic [ROB_IDX_W-1:0]  alloc_idx,
  input  logic [EX_REG_NUMBER_WIDTH-1:0] alloc_rd,
  input  logic                  alloc_is_br,
  input  logic                  alloc_pred,
  input  logic                  wb_en,
  input  logic                  cdb_valid,
  input  logic [ROB_ID_W-1:0]   cdb_rob_id,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  input  logic                  cdb_taken,
  input  logic [DATA_WIDTH-1:0] cdb_target,
  input  logic                  free_en,
  input  logic [ROB_IDX_W-1:0]  head_idx,
  output rob_entry_t            head_ent,
  input  logic [ROB_ID_W-1:0]   qj_query,
  input  logic [ROB_ID_W-1:0]   qk_query,
  output logic                  vj_ready,
  output logic [DATA_WIDTH-1:0] vj_value,
  output logic                  vk_ready,
  output logic [DATA_WIDTH-1:0] vk_value
);

  rob_entry_t ents [ROB_SIZE];

  rob_idx_t cdb_idx;
  logic     cdb_in_range;

  assign cdb_idx      = cdb_rob_id[ROB_IDX_W-1:0];
  assign cdb_in_range = !cdb_rob_id[ROB_IDX_W];
  assign head_ent     = ents[head_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SIZE; i++)
        ents[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ents[i].busy  <= 1'b0;
        ents[i].ready <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        ents[alloc_idx].busy  <= 1'b1;
        ents[alloc_idx].ready <= 1'b0;
        ents[alloc_idx].rd    <= alloc_rd;
        ents[alloc_idx].is_br <= alloc_is_br;
        ents[alloc_idx].pred  <= alloc_pred;
      end
      if (wb_en && cdb_in_range && ents[cdb_idx].busy) begin
        ents[cdb_idx].ready  <= 1'b1;
        ents[cdb_idx].value  <= cdb_value;
        ents[cdb_idx].taken  <= cdb_taken;
        ents[cdb_idx].target <= cdb_target;
      end
      if (free_en) begin
        ents[head_idx].busy  <= 1'b0;
        ents[head_idx].ready <= 1'b0;
      end
    end
  end

  // {ready, value}; a same-cycle broadcast wins over stored state
  function automatic logic [DATA_WIDTH:0] lookup(rob_id_t q);
    if (q == NON_DEPENDENT)
      return {1'b1, {DATA_WIDTH{1'b0}}};
    else if (cdb_valid && cdb_rob_id == q)
      return {1'b1, cdb_value};
    else if (!q[ROB_IDX_W] && ents[q[ROB_IDX_W-1:0]].ready)
      return {1'b1, ents[q[ROB_IDX_W-1:0]].value};
    else
      return '0;
  endfunction

  always_comb begin
    {vj_ready, vj_value} = lookup(qj_query);
    {vk_ready, vk_value} = lookup(qk_query);
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocation, CDB capture, commit
// and branch mispredict flush for the Tomasulo core.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  alloc_valid,
  input  logic [EX_REG_NUMBER_WIDTH-1:0] alloc_rd,
  input  logic                  alloc_is_br,
  input  logic                  alloc_pred_taken,
  output logic [ROB_ID_W-1:0]   rob_id_to_dsp,
  output logic                  rob_full,
  input  logic [ROB_ID_W-1:0]   qj_query,
  input  logic [ROB_ID_W-1:0]   qk_query,
  output logic                  vj_ready,
  output logic [DATA_WIDTH-1:0] vj_value,
  output logic                  vk_ready,
  output logic [DATA_WIDTH-1:0] vk_value,
  input  logic                  cdb_valid,
  input  logic [ROB_ID_W-1:0]   cdb_rob_id,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  input  logic                  cdb_taken,
  input  logic [DATA_WIDTH-1:0] cdb_target,
  output logic                  commit_en,
  output logic [EX_REG_NUMBER_WIDTH-1:0] commit_rd,
  output logic [ROB_ID_W-1:0]   commit_q,
  output logic [DATA_WIDTH-1:0] commit_v,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  rob_idx_t           head;
  rob_idx_t           tail;
  logic [ROB_IDX_W:0] count;
  rob_entry_t         head_ent;

  logic alloc_en;
  logic wb_en;
  logic do_commit;
  logic br_miss;
  logic flush;
  logic free_en;

  assign rob_full      = (count == (ROB_IDX_W+1)'(ROB_SIZE));
  assign rob_id_to_dsp = {1'b0, tail};

  // the cycle after a flush belongs to the redirect; ignore new work
  assign alloc_en  = rdy && alloc_valid && !rob_full && !mispredict;
  assign wb_en     = rdy && cdb_valid && !mispredict;
  assign do_commit = rdy && !mispredict && head_ent.busy && head_ent.ready;
  assign br_miss   = head_ent.is_br && (head_ent.taken != head_ent.pred);
  assign flush     = do_commit && br_miss;
  assign free_en   = do_commit && !br_miss;

  rob_entry_array u_array (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_en    (alloc_en),
    .alloc_idx   (tail),
    .alloc_rd    (alloc_rd),
    .alloc_is_br (alloc_is_br),
    .alloc_pred  (alloc_pred_taken),
    .wb_en       (wb_en),
    .cdb_valid   (cdb_valid),
    .cdb_rob_id  (cdb_rob_id),
    .cdb_value   (cdb_value),
    .cdb_taken   (cdb_taken),
    .cdb_target  (cdb_target),
    .free_en     (free_en),
    .head_idx    (head),
    .head_ent    (head_ent),
    .qj_query    (qj_query),
    .qk_query    (qk_query),
    .vj_ready    (vj_ready),
    .vj_value    (vj_value),
    .vk_ready    (vk_ready),
    .vk_value    (vk_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      commit_en   <= 1'b0;
      commit_rd   <= '0;
      commit_q    <= '0;
      commit_v    <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (!rdy) begin
      commit_en  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      commit_en  <= do_commit && writes_rd(head_ent.rd);
      mispredict <= flush;
      if (do_commit) begin
        commit_rd <= head_ent.rd;
        commit_q  <= {1'b0, head};
        commit_v  <= head_ent.value;
      end
      if (flush) begin
        redirect_pc <= head_ent.target;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (do_commit)
          head <= head + 1'b1;
        if (alloc_en)
          tail <= tail + 1'b1;
        count <= count + (ROB_IDX_W+1)'(alloc_en)
                       - (ROB_IDX_W+1)'(do_commit);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard,
// table-driven operand lookups and hand-written corner sequences.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [5:0]  alloc_rd = '0;
  logic        alloc_is_br = 1'b0;
  logic        alloc_pred_taken = 1'b0;
  logic [4:0]  rob_id_to_dsp;
  logic        rob_full;
  logic [4:0]  qj_query = '0;
  logic [4:0]  qk_query = '0;
  logic        vj_ready, vk_ready;
  logic [31:0] vj_value, vk_value;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_rob_id = '0;
  logic [31:0] cdb_value = '0;
  logic        cdb_taken = 1'b0;
  logic [31:0] cdb_target = '0;
  logic        commit_en;
  logic [5:0]  commit_rd;
  logic [4:0]  commit_q;
  logic [31:0] commit_v;
  logic        mispredict;
  logic [31:0] redirect_pc;

  reorder_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .alloc_valid      (alloc_valid),
    .alloc_rd         (alloc_rd),
    .alloc_is_br      (alloc_is_br),
    .alloc_pred_taken (alloc_pred_taken),
    .rob_id_to_dsp    (rob_id_to_dsp),
    .rob_full         (rob_full),
    .qj_query         (qj_query),
    .qk_query         (qk_query),
    .vj_ready         (vj_ready),
    .vj_value         (vj_value),
    .vk_ready         (vk_ready),
    .vk_value         (vk_value),
    .cdb_valid        (cdb_valid),
    .cdb_rob_id       (cdb_rob_id),
    .cdb_value        (cdb_value),
    .cdb_taken        (cdb_taken),
    .cdb_target       (cdb_target),
    .commit_en        (commit_en),
    .commit_rd        (commit_rd),
    .commit_q         (commit_q),
    .commit_v         (commit_v),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  rd;
    logic [4:0]  q;
    logic [31:0] v;
    logic        misp;
    logic [31:0] pc;
  } cexp_t;

  cexp_t exp_q[$];

  typedef struct {
    logic [4:0]  qj;
    logic [4:0]  qk;
    logic        cv;
    logic [4:0]  cid;
    logic [31:0] cval;
    logic        ejr;
    logic [31:0] ejv;
    logic        ekr;
    logic [31:0] ekv;
  } qvec_t;

  qvec_t vecs[5];

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [5:0] rd, logic [4:0] q, logic [31:0] v,
                      logic misp, logic [31:0] pc);
    cexp_t e;
    e.rd = rd; e.q = q; e.v = v; e.misp = misp; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic cdb(logic [4:0] id, logic [31:0] v,
                     logic tk, logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_value = v;
    cdb_taken = tk; cdb_target = tgt;
  endtask

  // commit monitor: every visible commit/flush must match the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst && (commit_en || mispredict)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit rd=%0d q=%0d v=%h misp=%b",
                   commit_rd, commit_q, commit_v, mispredict);
        end else begin
          cexp_t e;
          e = exp_q.pop_front();
          chk("commit_en", 32'(commit_en), 32'd1);
          chk("commit_rd", 32'(commit_rd), 32'(e.rd));
          chk("commit_q", 32'(commit_q), 32'(e.q));
          chk("commit_v", commit_v, e.v);
          chk("mispredict", 32'(mispredict), 32'(e.misp));
          if (e.misp) chk("redirect_pc", redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{5'd2,  5'd7,  1'b1, 5'd2, 32'h55, 1'b1, 32'h55, 1'b1, 32'h77};
    vecs[1] = '{5'd16, 5'd2,  1'b0, 5'd0, 32'h00, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2] = '{5'd7,  5'd16, 1'b1, 5'd9, 32'h99, 1'b1, 32'h77, 1'b1, 32'h00};
    vecs[3] = '{5'd9,  5'd8,  1'b1, 5'd9, 32'h99, 1'b1, 32'h99, 1'b0, 32'h00};
    vecs[4] = '{5'd8,  5'd9,  1'b0, 5'd9, 32'h99, 1'b0, 32'h00, 1'b0, 32'h00};

    // reset state
    #12;
    chk("rst_commit_en", 32'(commit_en), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_id", 32'(rob_id_to_dsp), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    rst = 1'b1;
    step();

    // basic out-of-order writeback, in-order commit
    alloc_valid = 1'b1;
    alloc_rd = 6'd5; step(); chk("id_after1", 32'(rob_id_to_dsp), 32'd1);
    alloc_rd = 6'd6; step(); chk("id_after2", 32'(rob_id_to_dsp), 32'd2);
    alloc_rd = 6'd0; step(); chk("id_after3", 32'(rob_id_to_dsp), 32'd3);
    alloc_valid = 1'b0;
    push(6'd5, 5'd0, 32'd9, 1'b0, 32'd0);
    push(6'd6, 5'd1, 32'd7, 1'b0, 32'd0);
    cdb(5'd1, 32'd7, 1'b0, 32'd0); step();
    chk("no_early_commit", 32'(commit_en), 32'd0);
    cdb(5'd0, 32'd9, 1'b0, 32'd0); step();
    chk("cdb_to_commit_gap", 32'(commit_en), 32'd0);
    cdb(5'd2, 32'd3, 1'b0, 32'd0); step();
    cdb_valid = 1'b0; step();
    step();
    chk("rd0_commit_en", 32'(commit_en), 32'd0);
    chk("rd0_commit_q", 32'(commit_q), 32'd2);
    step();

    // fill to full across the pointer wrap, then commit and alloc together
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_rd = 6'(i + 1);
      step();
    end
    chk("full_after16", 32'(rob_full), 32'd1);
    chk("tail_wrap", 32'(rob_id_to_dsp), 32'd3);
    alloc_rd = 6'd20; step();
    chk("alloc17_full", 32'(rob_full), 32'd1);
    chk("alloc17_ignored", 32'(rob_id_to_dsp), 32'd3);
    push(6'd1, 5'd3, 32'hA1, 1'b0, 32'd0);
    cdb(5'd3, 32'hA1, 1'b0, 32'd0); alloc_rd = 6'd21; step();
    chk("w0_full", 32'(rob_full), 32'd1);
    push(6'd2, 5'd4, 32'hA2, 1'b0, 32'd0);
    cdb(5'd4, 32'hA2, 1'b0, 32'd0); step();
    chk("w1_full", 32'(rob_full), 32'd0);
    chk("w1_id", 32'(rob_id_to_dsp), 32'd3);
    cdb_valid = 1'b0; step();
    chk("w2_full_same_count", 32'(rob_full), 32'd0);
    chk("w2_id", 32'(rob_id_to_dsp), 32'd4);
    alloc_rd = 6'd22; step();
    chk("w3_full", 32'(rob_full), 32'd1);
    chk("w3_id", 32'(rob_id_to_dsp), 32'd5);
    alloc_valid = 1'b0;

    // operand lookup table, applied with the block frozen
    cdb(5'd7, 32'h77, 1'b0, 32'd0); step();
    cdb_valid = 1'b0;
    rdy = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      qj_query = vecs[i].qj; qk_query = vecs[i].qk;
      cdb_valid = vecs[i].cv; cdb_rob_id = vecs[i].cid;
      cdb_value = vecs[i].cval;
      #1;
      chk($sformatf("q%0d_vj_ready", i), 32'(vj_ready), 32'(vecs[i].ejr));
      chk($sformatf("q%0d_vj_value", i), vj_value, vecs[i].ejv);
      chk($sformatf("q%0d_vk_ready", i), 32'(vk_ready), 32'(vecs[i].ekr));
      chk($sformatf("q%0d_vk_value", i), vk_value, vecs[i].ekv);
    end
    cdb_valid = 1'b0;
    rdy = 1'b1;
    step();

    // asynchronous reset with a full buffer
    #3; rst = 1'b0; #1;
    chk("arst_commit_rd", 32'(commit_rd), 32'd0);
    chk("arst_commit_q", 32'(commit_q), 32'd0);
    chk("arst_commit_v", commit_v, 32'd0);
    chk("arst_full", 32'(rob_full), 32'd0);
    chk("arst_id", 32'(rob_id_to_dsp), 32'd0);
    rst = 1'b1;
    step();

    // mispredicted branch with four younger entries
    alloc_valid = 1'b1; alloc_rd = 6'd3;
    alloc_is_br = 1'b1; alloc_pred_taken = 1'b0;
    step();
    alloc_is_br = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc_rd = 6'(8 + i);
      step();
    end
    alloc_valid = 1'b0;
    chk("br_id", 32'(rob_id_to_dsp), 32'd5);
    push(6'd3, 5'd0, 32'h44, 1'b1, 32'h100);
    cdb(5'd0, 32'h44, 1'b1, 32'h100); step();
    cdb_valid = 1'b0; cdb_taken = 1'b0; step();
    chk("misp_high", 32'(mispredict), 32'd1);
    chk("misp_pc", redirect_pc, 32'h100);
    chk("misp_id", 32'(rob_id_to_dsp), 32'd0);
    chk("misp_full", 32'(rob_full), 32'd0);
    alloc_valid = 1'b1; alloc_rd = 6'd9;
    cdb(5'd2, 32'd5, 1'b0, 32'd0); step();
    alloc_valid = 1'b0; cdb_valid = 1'b0; qj_query = 5'd2;
    #1;
    chk("misp_one_cycle", 32'(mispredict), 32'd0);
    chk("misp_alloc_ignored", 32'(rob_id_to_dsp), 32'd0);
    chk("misp_cdb_ignored", 32'(vj_ready), 32'd0);

    // correctly predicted branch: commit, no flush
    alloc_valid = 1'b1; alloc_rd = 6'd4;
    alloc_is_br = 1'b1; alloc_pred_taken = 1'b1;
    step();
    alloc_valid = 1'b0; alloc_is_br = 1'b0; alloc_pred_taken = 1'b0;
    push(6'd4, 5'd0, 32'h10, 1'b0, 32'd0);
    cdb(5'd0, 32'h10, 1'b1, 32'h200); step();
    cdb_valid = 1'b0; cdb_taken = 1'b0; step();
    chk("br_ok_commit", 32'(commit_en), 32'd1);
    chk("br_ok_no_misp", 32'(mispredict), 32'd0);
    step();

    // rdy low stalls a ready head
    alloc_valid = 1'b1; alloc_rd = 6'd12; step();
    alloc_valid = 1'b0;
    cdb(5'd1, 32'h3C, 1'b0, 32'd0); step();
    cdb_valid = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_commit_en", i), 32'(commit_en), 32'd0);
    end
    push(6'd12, 5'd1, 32'h3C, 1'b0, 32'd0);
    rdy = 1'b1; step();
    chk("resume_commit", 32'(commit_en), 32'd1);
    step();

    // async reset with five busy entries, then restart from id 0
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_rd = 6'(1 + i);
      step();
    end
    alloc_valid = 1'b0;
    chk("five_busy_id", 32'(rob_id_to_dsp), 32'd7);
    #3; rst = 1'b0; #1;
    chk("arst2_id", 32'(rob_id_to_dsp), 32'd0);
    chk("arst2_commit_q", 32'(commit_q), 32'd0);
    rst = 1'b1;
    step();
    alloc_valid = 1'b1; alloc_rd = 6'd7; step();
    alloc_valid = 1'b0;
    chk("restart_id", 32'(rob_id_to_dsp), 32'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
